// File: rtl/branch_target_buffer.sv
// 2-way set-associative branch target buffer with next-PC select for the fetch stage.
// Lookup is combinational on pcF; targets are learned from taken branches resolved in M.
module branch_target_buffer #(
    parameter int SETS_LOG2 = 4,
    parameter int TAG_W     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic        stallF,
    input  logic        pcsrcPF,
    input  logic        branchM,
    input  logic        pcsrcM,
    input  logic [31:0] pcM,
    input  logic [31:0] targetM,
    input  logic        pmisM,
    input  logic [31:0] fpcM,
    output logic        hitF,
    output logic [31:0] targetF,
    output logic        takenF,
    output logic [31:0] npcF
);
    localparam int SETS = 1 << SETS_LOG2;

    logic                 valid   [2][SETS];
    logic [TAG_W-1:0]     tags    [2][SETS];
    logic [31:0]          targets [2][SETS];
    logic [SETS-1:0]      lru;

    logic [SETS_LOG2-1:0] idx_f, idx_m;
    logic [TAG_W-1:0]     tag_f, tag_m;
    logic [1:0]           hit_way_f, hit_way_m;
    logic                 upd;
    logic                 upd_way;

    assign idx_f = pcF[SETS_LOG2+1:2];
    assign idx_m = pcM[SETS_LOG2+1:2];
    assign tag_f = pcF[SETS_LOG2+TAG_W+1:SETS_LOG2+2];
    assign tag_m = pcM[SETS_LOG2+TAG_W+1:SETS_LOG2+2];

    // Offset and upper pc bits take no part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pcF[31:SETS_LOG2+TAG_W+2], pcF[1:0],
                              pcM[31:SETS_LOG2+TAG_W+2], pcM[1:0]};

    always_comb begin
        for (int w = 0; w < 2; w++) begin
            hit_way_f[w] = valid[w][idx_f] && (tags[w][idx_f] == tag_f);
            hit_way_m[w] = valid[w][idx_m] && (tags[w][idx_m] == tag_m);
        end
    end

    // Reset gating keeps the lookup quiet while state is being cleared.
    assign hitF = (|hit_way_f) & ~rst;

    always_comb begin
        targetF = 32'h0;
        if (hitF)
            targetF = hit_way_f[0] ? targets[0][idx_f] : targets[1][idx_f];
    end

    assign takenF = hitF & pcsrcPF;
    assign npcF   = pmisM  ? fpcM :
                    takenF ? targetF : pcF + 32'd4;

    assign upd = branchM & pcsrcM;

    // Hit way first, then lowest invalid way, then the LRU victim.
    always_comb begin
        if (hit_way_m[0])              upd_way = 1'b0;
        else if (hit_way_m[1])         upd_way = 1'b1;
        else if (!valid[0][idx_m])     upd_way = 1'b0;
        else if (!valid[1][idx_m])     upd_way = 1'b1;
        else                           upd_way = lru[idx_m];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < 2; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid[w][s]   <= 1'b0;
                    tags[w][s]    <= '0;
                    targets[w][s] <= 32'h0;
                end
            end
            lru <= '0;
        end else begin
            // lru gets the way not hit; way0 wins when both match.
            if (hitF && !stallF && !(upd && idx_m == idx_f))
                lru[idx_f] <= hit_way_f[0];
            if (upd) begin
                valid[upd_way][idx_m]   <= 1'b1;
                tags[upd_way][idx_m]    <= tag_m;
                targets[upd_way][idx_m] <= targetM;
                lru[idx_m]              <= ~upd_way;
            end
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed vector table plus randomized run against a recency-based BTB model.
module tb_branch_target_buffer;
    logic        clk = 1'b0;
    logic        rst, stallF, pcsrcPF, branchM, pcsrcM, pmisM;
    logic [31:0] pcF, pcM, targetM, fpcM;
    logic        hitF, takenF;
    logic [31:0] targetF, npcF;

    int checks = 0;
    int errors = 0;

    branch_target_buffer #(.SETS_LOG2(4), .TAG_W(10)) dut (
        .clk(clk), .rst(rst), .pcF(pcF), .stallF(stallF), .pcsrcPF(pcsrcPF),
        .branchM(branchM), .pcsrcM(pcsrcM), .pcM(pcM), .targetM(targetM),
        .pmisM(pmisM), .fpcM(fpcM), .hitF(hitF), .targetF(targetF),
        .takenF(takenF), .npcF(npcF)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        stall;
        logic        psrc;
        logic        br;
        logic        tk;
        logic [31:0] pcm;
        logic [31:0] tgm;
        logic        pmis;
        logic [31:0] fpc;
        logic        e_hit;
        logic [31:0] e_tgt;
        logic [31:0] e_npc;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic r, input logic [31:0] pc, input logic st, input logic ps,
                       input logic br, input logic tk, input logic [31:0] pcm,
                       input logic [31:0] tgm, input logic pm, input logic [31:0] fpc,
                       input logic eh, input logic [31:0] et, input logic [31:0] en);
        vec_t v;
        v.rst = r; v.pc = pc; v.stall = st; v.psrc = ps; v.br = br; v.tk = tk;
        v.pcm = pcm; v.tgm = tgm; v.pmis = pm; v.fpc = fpc;
        v.e_hit = eh; v.e_tgt = et; v.e_npc = en;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] pc, input logic st, input logic ps,
                         input logic br, input logic tk, input logic [31:0] pcm,
                         input logic [31:0] tgm, input logic pm, input logic [31:0] fpc);
        rst = r; pcF = pc; stallF = st; pcsrcPF = ps; branchM = br; pcsrcM = tk;
        pcM = pcm; targetM = tgm; pmisM = pm; fpcM = fpc;
    endtask

    // Reference model: per set, two entries and the most recently touched way.
    bit          m_valid [16][2];
    int          m_tag   [16][2];
    logic [31:0] m_tgt   [16][2];
    int          m_mru   [16];

    function automatic int set_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'hF);
    endfunction
    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> 6) & 32'h3FF);
    endfunction

    task automatic m_clear();
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 2; w++) begin
                m_valid[s][w] = 0; m_tag[s][w] = 0; m_tgt[s][w] = 0;
            end
            m_mru[s] = 1;
        end
    endtask

    task automatic m_lookup(input logic [31:0] pc, output bit h, output int w,
                            output logic [31:0] t);
        int s = set_of(pc);
        h = 0; w = 0; t = 0;
        for (int i = 1; i >= 0; i--)
            if (m_valid[s][i] && m_tag[s][i] == tag_of(pc)) begin
                h = 1; w = i; t = m_tgt[s][i];
            end
    endtask

    task automatic m_edge();
        bit h, hm; int w, wm; logic [31:0] t, tm; bit upd;
        if (rst) begin
            m_clear();
            return;
        end
        m_lookup(pcF, h, w, t);
        upd = branchM && pcsrcM;
        if (h && !stallF && !(upd && set_of(pcM) == set_of(pcF)))
            m_mru[set_of(pcF)] = w;
        if (upd) begin
            int s = set_of(pcM);
            m_lookup(pcM, hm, wm, tm);
            if (!hm) begin
                if (!m_valid[s][0])      wm = 0;
                else if (!m_valid[s][1]) wm = 1;
                else                     wm = 1 - m_mru[s];
            end
            m_valid[s][wm] = 1; m_tag[s][wm] = tag_of(pcM); m_tgt[s][wm] = targetM;
            m_mru[s] = wm;
        end
    endtask

    function automatic logic [31:0] pool_pc();
        return 32'h0040_0000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 2) << 2);
    endfunction

    localparam logic [31:0] A = 32'h0040_0010, B = 32'h0040_0410, C = 32'h0040_0810;
    localparam logic [31:0] TA = 32'h0040_0100, TB = 32'h0040_0200, TC = 32'h0040_0300;
    localparam logic [31:0] Z = 32'h0000_1000;

    initial begin
        //  rst pc    st ps br tk pcm  tgm  pm fpc            hit tgt npc
        add(0, A,     0, 1, 0, 0, 0,   0,   0, 0,             0, 0,  A + 4);
        add(0, A,     0, 1, 1, 1, A,   TA,  0, 0,             0, 0,  A + 4);
        add(0, A,     0, 1, 0, 0, 0,   0,   0, 0,             1, TA, TA);
        add(0, A,     0, 0, 0, 0, 0,   0,   0, 0,             1, TA, A + 4);
        add(0, Z,     0, 0, 1, 1, B,   TB,  0, 0,             0, 0,  Z + 4);
        add(0, A,     0, 1, 0, 0, 0,   0,   0, 0,             1, TA, TA);
        add(0, Z,     0, 0, 1, 1, C,   TC,  0, 0,             0, 0,  Z + 4);
        add(0, B,     0, 1, 0, 0, 0,   0,   0, 0,             0, 0,  B + 4);
        add(0, C,     0, 1, 0, 0, 0,   0,   0, 0,             1, TC, TC);
        add(0, A,     1, 0, 0, 0, 0,   0,   0, 0,             1, TA, A + 4);
        add(0, Z,     0, 0, 1, 1, B,   TB,  0, 0,             0, 0,  Z + 4);
        add(0, A,     0, 1, 0, 0, 0,   0,   0, 0,             0, 0,  A + 4);
        add(0, C,     0, 1, 0, 0, 0,   0,   0, 0,             1, TC, TC);
        add(0, B,     0, 1, 0, 0, 0,   0,   0, 0,             1, TB, TB);
        add(0, B,     0, 1, 1, 0, B, 32'hDEAD0000, 0, 0,      1, TB, TB);
        add(0, B,     0, 1, 0, 0, 0,   0,   0, 0,             1, TB, TB);
        add(0, B,     0, 1, 0, 0, 0,   0,   1, 32'h00400020,  1, TB, 32'h00400020);
        add(0, 32'hFFFFFFFC, 0, 1, 0, 0, 0, 0, 0, 0,          0, 0,  32'h0);
        add(0, 32'h2000, 0, 1, 0, 1, 32'h2000, 32'h1234, 0, 0, 0, 0,  32'h2004);
        add(0, 32'h2000, 0, 1, 0, 0, 0,   0,   0, 0,          0, 0,  32'h2004);
        add(1, B,     0, 1, 0, 0, 0,   0,   0, 0,             0, 0,  B + 4);
        add(1, B,     0, 1, 0, 0, 0,   0,   1, 32'h40,        0, 0,  32'h40);
        add(0, B,     0, 1, 0, 0, 0,   0,   0, 0,             0, 0,  B + 4);

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].pc, vecs[i].stall, vecs[i].psrc, vecs[i].br,
                  vecs[i].tk, vecs[i].pcm, vecs[i].tgm, vecs[i].pmis, vecs[i].fpc);
            #4;
            chk($sformatf("vec%0d hitF", i), {31'b0, hitF}, {31'b0, vecs[i].e_hit});
            chk($sformatf("vec%0d targetF", i), targetF, vecs[i].e_tgt);
            chk($sformatf("vec%0d takenF", i), {31'b0, takenF},
                {31'b0, vecs[i].e_hit & vecs[i].psrc});
            chk($sformatf("vec%0d npcF", i), npcF, vecs[i].e_npc);
            @(negedge clk);
        end

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        m_clear();
        @(negedge clk);

        for (int c = 0; c < 800; c++) begin
            bit h; int w; logic [31:0] t, en;
            drive($urandom_range(0, 59) == 0, pool_pc(), $urandom_range(0, 3) == 0,
                  1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, pool_pc(),
                  $urandom & 32'hFFFFFFFC, $urandom_range(0, 7) == 0, $urandom);
            m_lookup(pcF, h, w, t);
            if (rst) begin h = 0; t = 0; end
            en = pmisM ? fpcM : (h && pcsrcPF) ? t : pcF + 32'd4;
            #4;
            chk("rand hitF", {31'b0, hitF}, {31'b0, h});
            chk("rand targetF", targetF, t);
            chk("rand takenF", {31'b0, takenF}, {31'b0, h & pcsrcPF});
            chk("rand npcF", npcF, en);
            @(posedge clk);
            m_edge();
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- 2-way set-associative branch target buffer with a next-PC select, in the fetch stage next to the direction predictor.
- Looks up the F-stage pc and returns a cached taken-target. Combines that target with the predictor's direction bit (pcsrcPF) to form the predicted next pc.
- Learns targets from resolved branches in the M stage.
- Redirects fetch to the correct pc on a misprediction.

Parameters:
- SETS_LOG2, 4, log2 of set count (16 sets); index = pc[SETS_LOG2+1:2].
- TAG_W, 10, tag width; tag = pc[SETS_LOG2+TAG_W+1:SETS_LOG2+2].

Ports:
- clk  input  1  clock
- rst  input  1  reset
- pcF  input  32  current fetch pc
- stallF  input  1  fetch stalled; suppresses lookup-side LRU update
- pcsrcPF  input  1  predicted direction from the direction predictor for pcF
- branchM  input  1  M-stage instruction is a branch
- pcsrcM  input  1  actual M-stage branch direction (1 = taken)
- pcM  input  32  pc of the M-stage branch
- targetM  input  32  actual taken target of the M-stage branch
- pmisM  input  1  M-stage direction misprediction
- fpcM  input  32  correct recovery pc for the M-stage branch
- hitF  output  1  tag hit for pcF
- targetF  output  32  cached target on hit, else 0
- takenF  output  1  hitF & pcsrcPF
- npcF  output  32  next fetch pc

Behaviour:
- Reset: rst, synchronous, active-high; clock clk.
  - While rst is high, all valid bits, tags, targets and per-set LRU bits are cleared to 0 at the edge.
  - Lookup outputs are combinational, so during reset and the cycle after, hitF=0, targetF=0 and takenF=0.
  - During reset, npcF = pcF+4, or fpcM if pmisM=1.
- Storage per set and way: valid(1), tag(TAG_W), target(32). Each set has one lru bit: 0 means way0 is next victim, 1 means way1 is next victim.
- Lookup (combinational, zero latency):
  - hitF = OR over both ways of (valid & tag==tagF).
  - A single tag match is assumed by construction; if both ways match, way0 has priority.
  - targetF = matching target, else 32'h0.
- npcF priority:
  - pmisM=1 → fpcM.
  - else takenF=1 → targetF.
  - else pcF+4 (32-bit wrap, 0xFFFFFFFC+4 = 0).
- LRU on lookup:
  - At the edge, when hitF & !stallF & !rst, the set's lru bit points to the way NOT hit.
  - Skipped when an update writes the same set that cycle; the update takes priority.
- Update (write at edge, when branchM & pcsrcM & !rst):
  - Tag hit in way w: overwrite target[w] with targetM; lru = ~w.
  - Miss, some way invalid: allocate the lowest invalid way w; write valid=1, tag, target; lru = ~w.
  - Miss, both ways valid: replace way lru; then lru = ~(replaced way).
- branchM & !pcsrcM: no change to any entry (direction comes from the predictor).
- branchM=0: no update; pcM, targetM and pcsrcM are ignored.
- Same-cycle lookup and update to the same entry: lookup sees pre-edge contents (no write-through bypass). The new target is visible from the next cycle.
- pmisM is independent of BTB state; it affects only npcF. Flushing is owned by the predictor and hazard logic.
- No multi-cycle operations, so reset mid-operation simply clears state.

Test Plan:
- Reset, then pcF=0x00400010, pcsrcPF=1 → hitF=0, takenF=0, npcF=0x00400014.
- Update branchM=1, pcsrcM=1, pcM=0x00400010, targetM=0x00400100.
  - Same cycle, pcF=0x00400010 → hitF=0.
  - Next cycle → hitF=1, targetF=0x00400100; npcF=0x00400100 if pcsrcPF=1, else 0x00400014.
- Fill set 4:
  - Taken updates for 0x00400010, then 0x00400410 (target 0x00400200), then 0x00400810 (target 0x00400300).
  - Third update evicts 0x00400010 (LRU). Lookups: 0x00400410 hit, 0x00400810 hit, 0x00400010 miss.
- LRU refresh:
  - After the first two fills, lookup 0x00400010 with stallF=0, then update 0x00400810 → 0x00400410 evicted.
  - Repeating with stallF=1 during the lookup → 0x00400010 evicted.
- Not-taken and mispredict:
  - branchM=1, pcsrcM=0 for a resident pc → entry unchanged.
  - pmisM=1, fpcM=0x00400020 with takenF=1 → npcF=0x00400020.
- Wrap: pcF=0xFFFFFFFC, miss → npcF=0x00000000.
